// File: rtl/piece_drop.sv
// Active tetromino controller and stack store; field_out reflects a move one cycle after the request.
// No backpressure: drop/left/right pulses outside FALL and start outside IDLE/OVER are dropped.
module piece_drop #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [3:0][3:0]            piece,
  input  logic                       drop_tick,
  input  logic                       left,
  input  logic                       right,
  output logic [ROWS-1:0][COLS-1:0]  field_out,
  output logic                       spawn_ack,
  output logic [7:0]                 lines,
  output logic                       game_over
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic signed [5:0] SPAWN_ROW = -6'sd1;
  localparam logic signed [4:0] SPAWN_COL = 5'((COLS - 4) / 2);

  typedef logic [ROWS-1:0][COLS-1:0] field_t;
  typedef enum logic [2:0] {IDLE, SPAWN, FALL, LOCK, CLEAR, OVER} state_t;

  // True if any set cell of p, boxed at (br, bc), leaves the field or hits the stack.
  function automatic logic hit(input logic [3:0][3:0] p, input int br, input int bc,
                               input field_t st);
    logic h;
    int   r;
    int   c;
    h = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (p[2'(i)][2'(j)]) begin
          r = br + 3 - i;
          c = bc + 3 - j;
          if (r < 0 || r >= ROWS || c < 0 || c >= COLS) h = 1'b1;
          else if (st[RW'(r)][CW'(c)]) h = 1'b1;
        end
      end
    end
    return h;
  endfunction

  function automatic field_t place(input logic [3:0][3:0] p, input int br, input int bc);
    field_t f;
    int     r;
    int     c;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r = br + 3 - i;
        c = bc + 3 - j;
        if (p[2'(i)][2'(j)] && r >= 0 && r < ROWS && c >= 0 && c < COLS)
          f[RW'(r)][CW'(c)] = 1'b1;
      end
    end
    return f;
  endfunction

  state_t                state, state_nxt;
  field_t                stack, stack_nxt;
  logic [3:0][3:0]       act, act_nxt;
  logic signed [5:0]     box_row, box_row_nxt;
  logic signed [4:0]     box_col, box_col_nxt;
  logic [7:0]            lines_nxt;
  logic [RW-1:0]         scan, scan_nxt;

  field_t img;
  logic   spawn_hit, down_hit, left_hit, right_hit, row_full;

  assign img       = place(act, int'(box_row), int'(box_col));
  assign spawn_hit = hit(piece, int'(SPAWN_ROW), int'(SPAWN_COL), stack);
  assign down_hit  = hit(act, int'(box_row) + 1, int'(box_col), stack);
  assign left_hit  = hit(act, int'(box_row), int'(box_col) - 1, stack);
  assign right_hit = hit(act, int'(box_row), int'(box_col) + 1, stack);
  assign row_full  = &stack[scan];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      stack   <= '0;
      act     <= '0;
      box_row <= SPAWN_ROW;
      box_col <= SPAWN_COL;
      lines   <= '0;
      scan    <= RW'(ROWS - 1);
    end else begin
      state   <= state_nxt;
      stack   <= stack_nxt;
      act     <= act_nxt;
      box_row <= box_row_nxt;
      box_col <= box_col_nxt;
      lines   <= lines_nxt;
      scan    <= scan_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    stack_nxt   = stack;
    act_nxt     = act;
    box_row_nxt = box_row;
    box_col_nxt = box_col;
    lines_nxt   = lines;
    scan_nxt    = scan;
    spawn_ack   = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          stack_nxt = '0;
          lines_nxt = '0;
          state_nxt = SPAWN;
        end
      end
      SPAWN: begin
        if (!spawn_hit) begin
          act_nxt     = piece;
          box_row_nxt = SPAWN_ROW;
          box_col_nxt = SPAWN_COL;
          spawn_ack   = 1'b1;
          state_nxt   = FALL;
        end else begin
          state_nxt = OVER;
        end
      end
      FALL: begin
        if (drop_tick) begin
          if (!down_hit) box_row_nxt = box_row + 6'sd1;
          else           state_nxt   = LOCK;
        end else if (left && !right) begin
          if (!left_hit) box_col_nxt = box_col - 5'sd1;
        end else if (right && !left) begin
          if (!right_hit) box_col_nxt = box_col + 5'sd1;
        end
      end
      LOCK: begin
        stack_nxt = stack | img;
        scan_nxt  = RW'(ROWS - 1);
        state_nxt = CLEAR;
      end
      CLEAR: begin
        // scan is held after a collapse so the row that dropped into it is re-examined
        if (row_full) begin
          for (int k = 1; k < ROWS; k++) begin
            if (k <= int'(scan)) stack_nxt[RW'(k)] = stack[RW'(k - 1)];
          end
          stack_nxt[0] = '0;
          if (lines != 8'hFF) lines_nxt = lines + 8'd1;
        end else if (scan != '0) begin
          scan_nxt = scan - RW'(1);
        end else begin
          state_nxt = SPAWN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign field_out = stack | ((state == FALL) ? img : '0);
  assign game_over = (state == OVER);

endmodule
